// File: rtl/rf_ctrl_pkg.sv
// Shared widths and helpers for the register-file port scheduler.
// The 8x16 register file geometry lives here so every block agrees on it.
package rf_ctrl_pkg;

   localparam int RF_DATA_W  = 16;
   localparam int RF_ADDR_W  = 3;
   localparam int RF_DEPTH   = 8;
   localparam int RF_MAX_REQ = 4;

   typedef logic [RF_DATA_W-1:0] rf_data_t;
   typedef logic [RF_ADDR_W-1:0] rf_addr_t;

   // Index of the set bit in a one-hot (or all-zero) grant vector.
   function automatic logic [1:0] onehot2idx(input logic [RF_MAX_REQ-1:0] oh);
      logic [1:0] idx;
      idx = '0;
      for (int i = 0; i < RF_MAX_REQ; i++) begin
         if (oh[i]) begin
            idx = idx | 2'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr, wrapping to the lowest index when nobody above ptr is asking.
module rr_arbiter #(
   parameter int N     = 2,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     gnt
);

   logic [N-1:0] upper;
   logic         found;

   // Two passes: requesters at/above the pointer first, then the wrapped set.
   always_comb begin
      upper = '0;
      gnt   = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         upper[i] = req[i] && (i >= int'(ptr));
      end
      for (int i = 0; i < N; i++) begin
         if (!found && upper[i]) begin
            gnt[i] = 1'b1;
            found  = 1'b1;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!found && req[i]) begin
            gnt[i] = 1'b1;
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rf_port_scheduler.sv
// Shares the register file's write port and A/B read pair among NUM_REQ clients.
// Optional macro RF_FWD_EN: forward same-cycle write data instead of stalling the read.
module rf_port_scheduler
   import rf_ctrl_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 2
) (
   input  logic                           CLK,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             wr_req,
   input  logic [RF_ADDR_W*NUM_REQ-1:0]   wr_reg,
   input  logic [RF_DATA_W*NUM_REQ-1:0]   wr_data,
   output logic [NUM_REQ-1:0]             wr_gnt,
   input  logic [NUM_REQ-1:0]             rd_req,
   input  logic [RF_ADDR_W*NUM_REQ-1:0]   rd_regA,
   input  logic [RF_ADDR_W*NUM_REQ-1:0]   rd_regB,
   output logic [NUM_REQ-1:0]             rd_gnt,
   output logic                           rd_valid,
   output logic [ID_W-1:0]                rd_id,
   output logic [RF_DATA_W-1:0]           rd_dataA,
   output logic [RF_DATA_W-1:0]           rd_dataB,
   output logic                           RFwrite,
   output logic [RF_ADDR_W-1:0]           regW,
   output logic [RF_DATA_W-1:0]           dataW,
   output logic [RF_ADDR_W-1:0]           regA,
   output logic [RF_ADDR_W-1:0]           regB,
   input  logic [RF_DATA_W-1:0]           dataA,
   input  logic [RF_DATA_W-1:0]           dataB
);

   localparam int PTR_W = $clog2(NUM_REQ);

   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   wr_ptr_nxt;
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   rd_ptr_nxt;
   logic [NUM_REQ-1:0] wr_arb_gnt;
   logic [NUM_REQ-1:0] rd_arb_gnt;
   logic [NUM_REQ-1:0] rd_cand;

   rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_wr_arb (
      .req (wr_req),
      .ptr (wr_ptr),
      .gnt (wr_arb_gnt)
   );

   // Grants are suppressed while reset is held so nothing reaches the file.
   assign wr_gnt  = reset ? {NUM_REQ{1'b0}} : wr_arb_gnt;
   assign RFwrite = |wr_gnt;

   always_comb begin
      regW       = '0;
      dataW      = '0;
      wr_ptr_nxt = wr_ptr;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (wr_gnt[i]) begin
            regW       = wr_reg[RF_ADDR_W*i +: RF_ADDR_W];
            dataW      = wr_data[RF_DATA_W*i +: RF_DATA_W];
            wr_ptr_nxt = (i == NUM_REQ-1) ? '0 : PTR_W'(i+1);
         end
      end
   end

`ifdef RF_FWD_EN
   assign rd_cand = rd_req;
`else
   logic [NUM_REQ-1:0] rd_hazard;

   // A read touching the register being written this cycle would see stale
   // data, so it sits out and the arbiter picks among the others.
   always_comb begin
      rd_hazard = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rd_hazard[i] = RFwrite &&
                        ((rd_regA[RF_ADDR_W*i +: RF_ADDR_W] == regW) ||
                         (rd_regB[RF_ADDR_W*i +: RF_ADDR_W] == regW));
      end
   end

   assign rd_cand = rd_req & ~rd_hazard;
`endif

   rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rd_arb (
      .req (rd_cand),
      .ptr (rd_ptr),
      .gnt (rd_arb_gnt)
   );

   assign rd_gnt = reset ? {NUM_REQ{1'b0}} : rd_arb_gnt;

   always_comb begin
      regA       = '0;
      regB       = '0;
      rd_ptr_nxt = rd_ptr;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rd_gnt[i]) begin
            regA       = rd_regA[RF_ADDR_W*i +: RF_ADDR_W];
            regB       = rd_regB[RF_ADDR_W*i +: RF_ADDR_W];
            rd_ptr_nxt = (i == NUM_REQ-1) ? '0 : PTR_W'(i+1);
         end
      end
   end

   // Pointers advance past the served client; the return tag tracks the file's
   // one-cycle registered read.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         rd_valid <= 1'b0;
         rd_id    <= '0;
      end else begin
         wr_ptr   <= wr_ptr_nxt;
         rd_ptr   <= rd_ptr_nxt;
         rd_valid <= |rd_gnt;
         if (|rd_gnt) begin
            rd_id <= ID_W'(onehot2idx(RF_MAX_REQ'(rd_gnt)));
         end
      end
   end

`ifdef RF_FWD_EN
   logic     hit_a;
   logic     hit_b;
   logic     fwd_a;
   logic     fwd_b;
   rf_data_t fwd_data;

   assign hit_a = RFwrite && (regA == regW);
   assign hit_b = RFwrite && (regB == regW);

   // The file returns the pre-write value on a same-cycle hit, so the
   // written word is captured and substituted on the affected operand.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         fwd_a    <= 1'b0;
         fwd_b    <= 1'b0;
         fwd_data <= '0;
      end else begin
         fwd_a <= (|rd_gnt) && hit_a;
         fwd_b <= (|rd_gnt) && hit_b;
         if (RFwrite) begin
            fwd_data <= dataW;
         end
      end
   end

   assign rd_dataA = fwd_a ? fwd_data : dataA;
   assign rd_dataB = fwd_b ? fwd_data : dataB;
`else
   assign rd_dataA = dataA;
   assign rd_dataB = dataB;
`endif

endmodule
